// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern generator: mode/speed widths, mode codes
// and ping-pong direction.
package led_pattern_pkg;

    localparam int MODE_W  = 2;
    localparam int SPEED_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_FLASH    = 2'd0,
        MODE_ROT_L    = 2'd1,
        MODE_ROT_R    = 2'd2,
        MODE_PINGPONG = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: counts enabled cycles and fires a one-cycle strobe when the
// count reaches the limit selected by speed, then wraps to zero.
module led_prescaler
    import led_pattern_pkg::*;
#(
    parameter int NB_COUNT = 32,
    parameter int COUNT_0  = 2**23,
    parameter int COUNT_1  = 2**24,
    parameter int COUNT_2  = 2**25,
    parameter int COUNT_3  = 2**26
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               clear,
    input  logic [SPEED_W-1:0] speed,
    output logic               strobe
);

    localparam logic [NB_COUNT-1:0] LIM_0 = NB_COUNT'(COUNT_0 - 1);
    localparam logic [NB_COUNT-1:0] LIM_1 = NB_COUNT'(COUNT_1 - 1);
    localparam logic [NB_COUNT-1:0] LIM_2 = NB_COUNT'(COUNT_2 - 1);
    localparam logic [NB_COUNT-1:0] LIM_3 = NB_COUNT'(COUNT_3 - 1);

    logic [NB_COUNT-1:0] count;
    logic [NB_COUNT-1:0] limit;

    always_comb begin
        limit = LIM_3;
        case (speed)
            2'd0:    limit = LIM_0;
            2'd1:    limit = LIM_1;
            2'd2:    limit = LIM_2;
            default: limit = LIM_3;
        endcase
    end

    // ">=" so that switching to a shorter period mid-count wraps on the next cycle
    assign strobe = enable & (count >= limit);

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (strobe) begin
            count <= '0;
        end else if (enable) begin
            count <= count + NB_COUNT'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Run-time selectable LED pattern generator (flash / rotate / ping-pong) at one of
// four step rates. Optional PWM dimming is compiled in with LED_PATTERN_GEN_PWM_EN.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NB_LEDS  = 4,
    parameter int NB_COUNT = 32,
    parameter int COUNT_0  = 2**23,
    parameter int COUNT_1  = 2**24,
    parameter int COUNT_2  = 2**25,
    parameter int COUNT_3  = 2**26
`ifdef LED_PATTERN_GEN_PWM_EN
    ,
    parameter int NB_PWM   = 8
`endif
) (
    input  logic               clock,
    input  logic               i_reset_n,
    input  logic               i_valid,
    input  logic [MODE_W-1:0]  i_mode,
    input  logic [SPEED_W-1:0] i_speed,
`ifdef LED_PATTERN_GEN_PWM_EN
    input  logic [NB_PWM-1:0]  i_duty,
`endif
    output logic [NB_LEDS-1:0] o_led,
    output logic               o_tick
);

    localparam logic [NB_LEDS-1:0] SEED = NB_LEDS'(1);

    logic [MODE_W-1:0]  mode_q;
    logic               mode_chg;
    logic               strobe;
    logic               step;
    logic [NB_LEDS-1:0] pattern, pattern_d;
    dir_t               dir, dir_d;
    logic               tick_q, tick_d;

    assign mode_chg = (i_mode != mode_q);
    // a mode change reseeds and swallows any strobe landing on the same edge
    assign step     = strobe & ~mode_chg;

    led_prescaler #(
        .NB_COUNT (NB_COUNT),
        .COUNT_0  (COUNT_0),
        .COUNT_1  (COUNT_1),
        .COUNT_2  (COUNT_2),
        .COUNT_3  (COUNT_3)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (i_reset_n),
        .enable  (i_valid),
        .clear   (mode_chg),
        .speed   (i_speed),
        .strobe  (strobe)
    );

    always_comb begin
        pattern_d = pattern;
        dir_d     = dir;
        tick_d    = 1'b0;
        if (mode_chg) begin
            pattern_d = SEED;
            dir_d     = DIR_LEFT;
        end else if (step) begin
            tick_d = 1'b1;
            case (mode_t'(mode_q))
                MODE_FLASH: pattern_d = ~pattern;
                MODE_ROT_L: pattern_d = {pattern[NB_LEDS-2:0], pattern[NB_LEDS-1]};
                MODE_ROT_R: pattern_d = {pattern[0], pattern[NB_LEDS-1:1]};
                MODE_PINGPONG: begin
                    // turn around as the one lands on an end, so ends show for one step
                    if (dir == DIR_LEFT) begin
                        pattern_d = pattern << 1;
                        if (pattern[NB_LEDS-2]) dir_d = DIR_RIGHT;
                    end else begin
                        pattern_d = pattern >> 1;
                        if (pattern[1]) dir_d = DIR_LEFT;
                    end
                end
                default: pattern_d = pattern;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset_n) begin
            pattern <= SEED;
            dir     <= DIR_LEFT;
            tick_q  <= 1'b0;
            mode_q  <= i_mode;
        end else begin
            pattern <= pattern_d;
            dir     <= dir_d;
            tick_q  <= tick_d;
            mode_q  <= i_mode;
        end
    end

`ifdef LED_PATTERN_GEN_PWM_EN
    logic [NB_PWM-1:0] pwm_cnt;

    // dimming stage adds one cycle; tick is delayed with it to stay aligned
    always_ff @(posedge clock) begin
        if (!i_reset_n) begin
            pwm_cnt <= '0;
            o_led   <= '0;
            o_tick  <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + NB_PWM'(1);
            o_led   <= pattern & {NB_LEDS{pwm_cnt < i_duty}};
            o_tick  <= tick_q;
        end
    end
`else
    assign o_led  = pattern;
    assign o_tick = tick_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with a step-index reference model checked
// every cycle, plus literal checks at the interesting points.
module tb_led_pattern_gen;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [1:0]   mode;
    logic [1:0]   speed;
    logic [N-1:0] led;
    logic         tick;
`ifdef LED_PATTERN_GEN_PWM_EN
    logic [7:0]   duty = 8'hff;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    led_pattern_gen #(
        .NB_LEDS  (N),
        .NB_COUNT (8),
        .COUNT_0  (4),
        .COUNT_1  (8),
        .COUNT_2  (16),
        .COUNT_3  (32)
    ) dut (
        .clock     (clock),
        .i_reset_n (rst_n),
        .i_valid   (valid),
        .i_mode    (mode),
        .i_speed   (speed),
`ifdef LED_PATTERN_GEN_PWM_EN
        .i_duty    (duty),
`endif
        .o_led     (led),
        .o_tick    (tick)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---- reference model: mode, steps taken since seed, prescaler phase ----
    int         m_k  = 0;
    int         m_ph = 0;
    logic [1:0] m_mode = 2'd0;
    bit         m_tick = 1'b0;
    bit         m_ok = 1'b0;

    function automatic int period(input logic [1:0] sp);
        case (sp)
            2'd0:    return 4;
            2'd1:    return 8;
            2'd2:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic logic [N-1:0] model_led(input logic [1:0] md, input int k);
        logic [N-1:0] s;
        int p;
        s = 1;
        case (md)
            2'd0: return (k % 2 == 1) ? ~s : s;
            2'd1: return s << (k % N);
            2'd2: return s << ((N - k % N) % N);
            default: begin
                p = k % (2 * N - 2);
                return s << ((p < N) ? p : (2 * N - 2 - p));
            end
        endcase
    endfunction

    always @(posedge clock) begin
        if (!rst_n) begin
            m_k <= 0; m_ph <= 0; m_tick <= 1'b0; m_ok <= 1'b1;
        end else if (mode != m_mode) begin
            m_k <= 0; m_ph <= 0; m_tick <= 1'b0;
        end else if (valid && m_ph >= period(speed) - 1) begin
            m_k <= m_k + 1; m_ph <= 0; m_tick <= 1'b1;
        end else begin
            m_tick <= 1'b0;
            if (valid) m_ph <= m_ph + 1;
        end
        m_mode <= mode;
    end

    always @(negedge clock) begin
        if (m_ok) begin
            chk("model_led", 32'(led), 32'(model_led(m_mode, m_k)));
            chk("model_tick", 32'(tick), 32'(m_tick));
        end
    end

    // ---- stimulus ----
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_tick(output int gap);
        int c0;
        c0  = cyc;
        gap = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (tick) begin
                gap = cyc - c0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL tick_timeout: got no tick expected one within 200 cycles");
    endtask

    initial begin
        int g;
        int c0;
        int pp[8] = '{1, 2, 4, 8, 4, 2, 1, 2};

        rst_n = 1'b0; valid = 1'b1; mode = 2'd2; speed = 2'd0;
        step(2);
        chk("rst_led", 32'(led), 32'h1);
        chk("rst_tick", 32'(tick), 32'h0);
        rst_n = 1'b1;
        wait_tick(g);
        chk("rst_first_gap", g, 4);
        chk("rst_first_led", 32'(led), 32'h8);

        // reset in the middle of a ROT_R run
        step(5);
        rst_n = 1'b0;
        step(1);
        chk("rst_mid_led", 32'(led), 32'h1);
        chk("rst_mid_tick", 32'(tick), 32'h0);
        rst_n = 1'b1;
        wait_tick(g);
        chk("rst_mid_gap", g, 4);
        chk("rst_mid_first_led", 32'(led), 32'h8);

        // FLASH at speed 1
        mode = 2'd0; speed = 2'd1;
        step(1);
        chk("flash_seed", 32'(led), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            wait_tick(g);
            chk("flash_gap", g, 8);
            chk("flash_led", 32'(led), (i % 2 == 1) ? 32'hE : 32'h1);
        end

        // PINGPONG at speed 0
        mode = 2'd3; speed = 2'd0;
        step(1);
        chk("pp_led0", 32'(led), 32'(pp[0]));
        for (int i = 1; i < 8; i++) begin
            wait_tick(g);
            chk("pp_gap", g, 4);
            chk("pp_led", 32'(led), 32'(pp[i]));
        end

        // ROT_L with a 10-cycle pause mid-count
        mode = 2'd1; speed = 2'd1;
        step(1);
        c0 = cyc;
        step(3);
        valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("pause_led_hold", 32'(led), 32'h1);
            chk("pause_no_tick", 32'(tick), 32'h0);
        end
        valid = 1'b1;
        wait_tick(g);
        chk("pause_step_at", cyc - c0, 18);
        chk("pause_led", 32'(led), 32'h2);

        // mode change landing on the same edge as a strobe
        wait_tick(g);
        chk("rotl_gap", g, 8);
        chk("rotl_led", 32'(led), 32'h4);
        step(7);
        chk("pre_change_led", 32'(led), 32'h4);
        mode = 2'd0;
        step(1);
        chk("chg_led", 32'(led), 32'h1);
        chk("chg_no_tick", 32'(tick), 32'h0);
        wait_tick(g);
        chk("chg_restart_gap", g, 8);
        chk("chg_restart_led", 32'(led), 32'hE);

        // speed 3 -> 0 with count at 20
        mode = 2'd1; speed = 2'd3;
        step(1);
        step(20);
        speed = 2'd0;
        step(1);
        chk("spd_tick_now", 32'(tick), 32'h1);
        chk("spd_led", 32'(led), 32'h2);
        for (int i = 0; i < 3; i++) begin
            wait_tick(g);
            chk("spd_gap", g, 4);
            chk("spd_led_seq", 32'(led), 32'(4'b0100 << i) & 32'hF | ((i == 2) ? 32'h1 : 32'h0));
        end

        // mode change while frozen still reseeds
        valid = 1'b0; mode = 2'd3;
        step(1);
        chk("frozen_chg_led", 32'(led), 32'h1);
        step(3);
        chk("frozen_hold_led", 32'(led), 32'h1);
        valid = 1'b1;
        wait_tick(g);
        chk("frozen_resume_gap", g, 4);
        chk("frozen_resume_led", 32'(led), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
